// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq
// Description : Sequential restoring divider. Divides a WIDTH-bit dividend by
//               a DWIDTH-bit divisor, resolving one quotient bit per clock,
//               MSB first, behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     dividend / quotient width (even, >= 2)
//   DWIDTH    divisor / remainder width (default WIDTH/2)
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   request, sampled in IDLE or DONE only
//   dividend   in   [WIDTH-1:0]  captured on accepted start
//   divisor    in   [DWIDTH-1:0] captured on accepted start
//   busy       out  high while the divide steps are running
//   done       out  one-cycle pulse, results valid from this cycle
//   quotient   out  [WIDTH-1:0]  last completed quotient
//   remainder  out  [DWIDTH-1:0] last completed remainder
//   dbz        out  last completed operation had divisor == 0
// Configuration macro
//   DIVIDER_SEQ_EARLY_DBZ_EN  when defined, a zero divisor skips the divide
//                             steps and completes one cycle after start.
// ============================================================================
module divider_seq #(
  parameter int WIDTH  = 4,
  parameter int DWIDTH = WIDTH / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef DIVIDER_SEQ_EARLY_DBZ_EN
  // Single-cycle detour used only for an early divide-by-zero completion.
  localparam logic [1:0] S_DBZ  = 2'd3;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  // r_dvd holds the remaining dividend bits in its upper part; quotient bits
  // are shifted into the bottom as the dividend bits leave the top, so after
  // WIDTH steps the register is the quotient.
  logic [WIDTH-1:0]  r_dvd;
  logic [DWIDTH-1:0] r_dvs;
  // Partial remainder after each step is always < divisor, so its top bit
  // (bit DWIDTH of R) is known zero between steps and is not stored.
  logic [DWIDTH-1:0] r_rem;
  logic [CW-1:0]     r_cnt;

  logic              w_accept;
  logic [DWIDTH:0]   w_shift;
  logic              w_ge;
  logic [DWIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0]  w_quo_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_load_run;
  logic              w_load_dbz;

  // --------------------------------------------------------------------------
  // Datapath for one restoring step
  // --------------------------------------------------------------------------
  assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  // When w_ge is set the true difference is < divisor, so the modulo-2^DWIDTH
  // subtraction of the low bits yields the exact result.
  assign w_rem_nxt = w_ge ? (w_shift[DWIDTH-1:0] - r_dvs) : w_shift[DWIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef DIVIDER_SEQ_EARLY_DBZ_EN
          w_state_nxt = (divisor == '0) ? S_DBZ : S_RUN;
`else
          w_state_nxt = S_RUN;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == C_CNT_ONE) begin
          w_state_nxt = S_DONE;
        end
      end
`ifdef DIVIDER_SEQ_EARLY_DBZ_EN
      S_DBZ: w_state_nxt = S_DONE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_load_run = (r_state == S_RUN) && (r_cnt == C_CNT_ONE);
`ifdef DIVIDER_SEQ_EARLY_DBZ_EN
    w_load_dbz = (r_state == S_DBZ);
`else
    w_load_dbz = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Operand / step registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_dvd <= dividend;
      r_dvs <= divisor;
      r_rem <= '0;
      r_cnt <= C_CNT_INIT;
    end else if (r_state == S_RUN) begin
      r_dvd <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - C_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs; results hold until the next completion
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_done_nxt;
      if (w_load_run) begin
        quotient  <= w_quo_nxt;
        remainder <= w_rem_nxt;
        dbz       <= (r_dvs == '0);
      end else if (w_load_dbz) begin
        // Same values the full restoring run produces for a zero divisor.
        quotient  <= '1;
        remainder <= r_dvd[DWIDTH-1:0];
        dbz       <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_seq
// Description : Self-checking bench for divider_seq (WIDTH=4, DWIDTH=2).
//               Directed vector table, exhaustive back-to-back sweep and
//               hand-written sequences for ignored start and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq;

  localparam int WIDTH  = 4;
  localparam int DWIDTH = 2;
`ifdef DIVIDER_SEQ_EARLY_DBZ_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  dividend;
  logic [DWIDTH-1:0] divisor;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  quotient;
  logic [DWIDTH-1:0] remainder;
  logic              dbz;

  int n_pass  = 0;
  int n_total = 0;
  int busy_cnt;
  int overlap;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int z;
  } vec_t;

  vec_t vecs[14];

  divider_seq #(.WIDTH(WIDTH), .DWIDTH(DWIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"},      int'(busy),      0);
    chk({tag, " done"},      int'(done),      0);
    chk({tag, " quotient"},  int'(quotient),  0);
    chk({tag, " remainder"}, int'(remainder), 0);
    chk({tag, " dbz"},       int'(dbz),       0);
  endtask

  // Present operands with start, let edge T0 accept, return at T0+1ns.
  task automatic launch(input int dvd, input int dvs);
    dividend = WIDTH'(dvd);
    divisor  = DWIDTH'(dvs);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = int'(busy);
    overlap  = 0;
  endtask

  // Edges after T0 until done is seen; 0 if it never comes within budget.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (busy && done) overlap++;
      if (done) begin
        lat = k;
        break;
      end
      busy_cnt += int'(busy);
    end
  endtask

  task automatic run_check(input string tag, input int dvd, input int dvs,
                           input int q, input int r, input int z);
    int lat;
    launch(dvd, dvs);
    wait_done(lat);
    chk($sformatf("%s %0d/%0d latency", tag, dvd, dvs), lat,
        (EARLY && dvs == 0) ? 1 : WIDTH);
    chk($sformatf("%s %0d/%0d busy cycles", tag, dvd, dvs), busy_cnt,
        (EARLY && dvs == 0) ? 0 : WIDTH);
    chk($sformatf("%s %0d/%0d busy&done", tag, dvd, dvs), overlap, 0);
    chk($sformatf("%s %0d/%0d quotient", tag, dvd, dvs), int'(quotient), q);
    chk($sformatf("%s %0d/%0d remainder", tag, dvd, dvs), int'(remainder), r);
    chk($sformatf("%s %0d/%0d dbz", tag, dvd, dvs), int'(dbz), z);
  endtask

  initial begin
    int pulses;
    int pulse_at;
    int ok;

    vecs[0]  = '{9, 2, 4, 1, 0};
    vecs[1]  = '{15, 3, 5, 0, 0};
    vecs[2]  = '{14, 3, 4, 2, 0};
    vecs[3]  = '{7, 2, 3, 1, 0};
    vecs[4]  = '{6, 0, 15, 2, 1};
    vecs[5]  = '{0, 1, 0, 0, 0};
    vecs[6]  = '{15, 1, 15, 0, 0};
    vecs[7]  = '{1, 3, 0, 1, 0};
    vecs[8]  = '{13, 0, 15, 1, 1};
    vecs[9]  = '{0, 0, 15, 0, 1};
    vecs[10] = '{11, 3, 3, 2, 0};
    vecs[11] = '{8, 3, 2, 2, 0};
    vecs[12] = '{15, 2, 7, 1, 0};
    vecs[13] = '{5, 3, 1, 2, 0};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset, then idle with no start.
    repeat (3) @(negedge clk);
    chk_reset_vals("in reset");
    reset = 1'b0;
    ok = 1;
    repeat (6) begin
      @(negedge clk);
      if (busy || done || quotient != 0 || remainder != 0 || dbz) ok = 0;
    end
    chk("idle outputs stay at reset values", ok, 1);

    // First operation from IDLE, plus the done fall afterwards.
    @(negedge clk);
    run_check("first", 9, 2, 4, 1, 0);
    @(posedge clk);
    #1;
    chk("done falls after one cycle", int'(done), 0);
    chk("busy low after done", int'(busy), 0);

    // Directed table, issued back-to-back out of DONE.
    for (int i = 0; i < 14; i++) begin
      run_check("vec", vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Exhaustive sweep, back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 0) run_check("sweep", a, b, 15, a % 4, 1);
        else        run_check("sweep", a, b, a / b, a % b, 0);
      end
    end

    // Start pulsed during RUN must be ignored.
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    launch(15, 3);
    dividend = 4'd1;
    divisor  = 2'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    pulses   = 0;
    pulse_at = 0;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        pulse_at = k;
        chk("ignored-start quotient at done", int'(quotient), 5);
        chk("ignored-start remainder at done", int'(remainder), 0);
      end
    end
    chk("ignored-start done pulses", pulses, 1);
    chk("ignored-start done edge", pulse_at, WIDTH);
    chk("ignored-start quotient holds", int'(quotient), 5);
    chk("ignored-start remainder holds", int'(remainder), 0);
    chk("ignored-start busy idle", int'(busy), 0);

    // Complete 14/3, then abort 12/1 with reset two cycles into RUN.
    run_check("pre-abort", 14, 3, 4, 2, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    launch(12, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("async reset");
    // Hold start through reset and release reset mid-cycle.
    dividend = 4'd7;
    divisor  = 2'd2;
    start    = 1'b1;
    ok = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done || busy) ok = 0;
    end
    chk("no done during reset", ok, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start accepted on first edge after reset", int'(busy), 1);
    busy_cnt = int'(busy);
    overlap  = 0;
    begin
      int lat;
      wait_done(lat);
      chk("post-reset latency", lat, WIDTH);
      chk("post-reset quotient", int'(quotient), 3);
      chk("post-reset remainder", int'(remainder), 1);
      chk("post-reset dbz", int'(dbz), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
